pipeline_hazard_ctrl: RTL and testbench

//  Central sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB).

---
 rtl/pipeline_pkg.sv | 16 +
 rtl/hazard_fwd_unit.sv | 44 ++++
 rtl/pipeline_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// hazard FSM states and the default register-address width.
package pipeline_pkg;

    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational EX-stage operand forwarding compare; the youngest producer
// (EX/MEM) wins over MEM/WB, and register 0 never forwards.
module hazard_fwd_unit
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_regwrite,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_regwrite,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel
);

    function automatic logic [1:0] pick_src(
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  m_we,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic                  w_we
    );
        logic [1:0] sel;
        if (src == {REG_ADDR_W{1'b0}}) begin
            sel = FWD_REG;
        end else if (m_we && (m_rd == src)) begin
            sel = FWD_EXMEM;
        end else if (w_we && (w_rd == src)) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

    // Operand A and B source selection
    always_comb begin
        fwd_a_sel = pick_src(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
        fwd_b_sel = pick_src(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencing controller: stalls, flushes, multi-cycle EX hold.
// Define HAZARD_FWD_EN to enable operand forwarding (only load-use then stalls).
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
    parameter int MC_LATENCY  = 4,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_ADDR_W-1:0]  ex_rs1,
    input  logic [REG_ADDR_W-1:0]  ex_rs2,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   ex_regwrite,
    input  logic                   ex_memread,
    input  logic                   ex_multicycle,
    input  logic                   ex_branch_taken,
    input  logic [REG_ADDR_W-1:0]  mem_rd,
    input  logic                   mem_regwrite,
    input  logic [REG_ADDR_W-1:0]  wb_rd,
    input  logic                   wb_regwrite,
    output logic                   pc_en,
    output logic                   if_id_en,
    output logic                   id_ex_en,
    output logic                   ex_mem_en,
    output logic                   if_id_flush,
    output logic                   id_ex_flush,
    output logic                   ex_mem_flush,
    output logic [1:0]             fwd_a_sel,
    output logic [1:0]             fwd_b_sel,
    output logic                   mc_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam int CNT_W = $clog2(MC_LATENCY);

    hz_state_e              state_q, state_d;
    logic [CNT_W-1:0]       mc_cnt_q, mc_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic ex_hit_s;
    logic mem_hit_s;
    logic load_use_s;
    logic data_stall_s;
    logic [1:0] fwd_a_raw_s;
    logic [1:0] fwd_b_raw_s;

    // Does the ID instruction read a given (non-zero) destination register?
    always_comb begin
        ex_hit_s  = (ex_rd != {REG_ADDR_W{1'b0}}) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
        mem_hit_s = (mem_rd != {REG_ADDR_W{1'b0}}) &&
                    ((id_use_rs1 && (id_rs1 == mem_rd)) || (id_use_rs2 && (id_rs2 == mem_rd)));
        load_use_s = ex_memread && ex_regwrite && ex_hit_s;
    end

`ifdef HAZARD_FWD_EN
    hazard_fwd_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_fwd (
        .ex_rs1       (ex_rs1),
        .ex_rs2       (ex_rs2),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_a_sel    (fwd_a_raw_s),
        .fwd_b_sel    (fwd_b_raw_s)
    );

    assign data_stall_s = load_use_s;
`else
    // Without forwarding the regfile is write-through, so WB producers never stall.
    logic unused_fwd_s;
    assign unused_fwd_s = ^{ex_rs1, ex_rs2, wb_rd, wb_regwrite};
    assign fwd_a_raw_s  = FWD_REG;
    assign fwd_b_raw_s  = FWD_REG;
    assign data_stall_s = (ex_regwrite && ex_hit_s) || (mem_regwrite && mem_hit_s);
`endif

    // Register controls and next-state for the hazard FSM
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mc_busy      = 1'b0;
        state_d      = state_q;
        mc_cnt_d     = mc_cnt_q;
        if (rst) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            state_d      = RUN;
            mc_cnt_d     = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (data_stall_s) begin
                        pc_en       = 1'b0;
                        if_id_en    = 1'b0;
                        id_ex_flush = 1'b1;
                    end else begin
                        pc_en       = 1'b1;
                    end
                    if (ex_multicycle) begin
                        state_d  = MC_BUSY;
                        mc_cnt_d = CNT_W'(MC_LATENCY - 1);
                    end else begin
                        state_d  = RUN;
                    end
                end
                MC_BUSY: begin
                    // Hazards and branches are not evaluated while the op owns EX.
                    if (mc_cnt_q == {CNT_W{1'b0}}) begin
                        state_d      = RUN;
                    end else begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_en     = 1'b0;
                        ex_mem_en    = 1'b0;
                        ex_mem_flush = 1'b1;
                        mc_busy      = 1'b1;
                        mc_cnt_d     = mc_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d  = RUN;
                    mc_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Forwarding selects forced to regfile during reset
    always_comb begin
        if (rst) begin
            fwd_a_sel = FWD_REG;
            fwd_b_sel = FWD_REG;
        end else begin
            fwd_a_sel = fwd_a_raw_s;
            fwd_b_sel = fwd_b_raw_s;
        end
    end

    // Saturating count of cycles with the PC held
    always_comb begin
        if (!pc_en && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, multi-cycle countdown and stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            mc_cnt_q    <= {CNT_W{1'b0}};
            stall_cnt_q <= {STALL_CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle model of the hazard
// rules checked every cycle, plus directed vectors with literal expectations.
module tb_pipeline_hazard_ctrl;

    localparam int RW    = 5;
    localparam int MCL   = 4;
    localparam int SCW   = 16;
    localparam int SCW_S = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [RW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_use_rs1, id_use_rs2, ex_regwrite, ex_memread;
    logic          ex_multicycle, ex_branch_taken, mem_regwrite, wb_regwrite;

    logic           pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic           if_id_flush, id_ex_flush, ex_mem_flush, mc_busy;
    logic [1:0]     fwd_a_sel, fwd_b_sel;
    logic [SCW-1:0] stall_count;

    logic             s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en;
    logic             s_if_id_flush, s_id_ex_flush, s_ex_mem_flush, s_mc_busy;
    logic [1:0]       s_fwd_a_sel, s_fwd_b_sel;
    logic [SCW_S-1:0] s_stall_count;

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .MC_LATENCY(MCL), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_multicycle(ex_multicycle), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mc_busy(mc_busy), .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .MC_LATENCY(MCL), .STALL_CNT_W(SCW_S)) dut_sat (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_multicycle(ex_multicycle), .ex_branch_taken(ex_branch_taken),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .pc_en(s_pc_en), .if_id_en(s_if_id_en), .id_ex_en(s_id_ex_en), .ex_mem_en(s_ex_mem_en),
        .if_id_flush(s_if_id_flush), .id_ex_flush(s_id_ex_flush), .ex_mem_flush(s_ex_mem_flush),
        .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel), .mc_busy(s_mc_busy), .stall_count(s_stall_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model state: EX cycles still owned by a multi-cycle op, and total stalls since reset.
    int m_left   = 0;
    int m_stalls = 0;

    function automatic bit id_reads(input logic [RW-1:0] rd);
        return (rd != 0) && ((id_use_rs1 && id_rs1 == rd) || (id_use_rs2 && id_rs2 == rd));
    endfunction

    function automatic bit model_stall();
`ifdef HAZARD_FWD_EN
        return ex_memread && ex_regwrite && id_reads(ex_rd);
`else
        return (ex_regwrite && id_reads(ex_rd)) || (mem_regwrite && id_reads(mem_rd));
`endif
    endfunction

    function automatic logic [1:0] model_fwd(input logic [RW-1:0] src);
`ifdef HAZARD_FWD_EN
        if (src != 0 && mem_regwrite && mem_rd == src) return 2'd1;
        if (src != 0 && wb_regwrite && wb_rd == src) return 2'd2;
`endif
        return 2'd0;
    endfunction

    logic       e_pc, e_ifid, e_idex, e_exmem, e_ifid_fl, e_idex_fl, e_exmem_fl, e_busy;
    logic [1:0] e_fa, e_fb;

    // Per-cycle comparison against the model, then advance the model
    always @(negedge clk) begin
        {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
        {e_ifid_fl, e_idex_fl, e_exmem_fl, e_busy} = 4'b0000;
        e_fa = 2'd0;
        e_fb = 2'd0;
        if (rst) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
            {e_ifid_fl, e_idex_fl, e_exmem_fl} = 3'b111;
        end else begin
            if (m_left > 1) begin
                {e_pc, e_ifid, e_idex, e_exmem} = 4'b0000;
                e_exmem_fl = 1'b1;
                e_busy     = 1'b1;
            end else if (m_left == 1) begin
                e_busy = 1'b0;
            end else if (ex_branch_taken) begin
                e_ifid_fl = 1'b1;
                e_idex_fl = 1'b1;
            end else if (model_stall()) begin
                e_pc      = 1'b0;
                e_ifid    = 1'b0;
                e_idex_fl = 1'b1;
            end
            e_fa = model_fwd(ex_rs1);
            e_fb = model_fwd(ex_rs2);
        end
        chk("pc_en", 32'(pc_en), 32'(e_pc));
        chk("if_id_en", 32'(if_id_en), 32'(e_ifid));
        chk("id_ex_en", 32'(id_ex_en), 32'(e_idex));
        chk("ex_mem_en", 32'(ex_mem_en), 32'(e_exmem));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_ifid_fl));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idex_fl));
        chk("ex_mem_flush", 32'(ex_mem_flush), 32'(e_exmem_fl));
        chk("mc_busy", 32'(mc_busy), 32'(e_busy));
        chk("fwd_a_sel", 32'(fwd_a_sel), 32'(e_fa));
        chk("fwd_b_sel", 32'(fwd_b_sel), 32'(e_fb));
        chk("stall_count", 32'(stall_count), 32'((m_stalls > 65535) ? 65535 : m_stalls));
        chk("stall_count_sat", 32'(s_stall_count), 32'((m_stalls > 3) ? 3 : m_stalls));
        if (rst) begin
            m_left   = 0;
            m_stalls = 0;
        end else begin
            if (!e_pc) m_stalls++;
            if (m_left > 0) m_left--;
            else if (ex_multicycle) m_left = MCL;
        end
    end

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_regwrite, ex_memread} = 4'b0000;
        {ex_multicycle, ex_branch_taken, mem_regwrite, wb_regwrite} = 4'b0000;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic load_use_x5();
        idle();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd5; id_use_rs1 = 1'b1; id_rs2 = 5'd6; id_use_rs2 = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // Reset held two cycles
        mid(); nxt();
        mid();
        chk("t1_rst_pc_en", 32'(pc_en), 32'd0);
        chk("t1_rst_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("t1_rst_stall_count", 32'(stall_count), 32'd0);
        nxt(); rst = 1'b0;
        mid();
        chk("t1_run_pc_en", 32'(pc_en), 32'd1);
        chk("t1_run_ex_mem_flush", 32'(ex_mem_flush), 32'd0);

        // Load-use on x5
        nxt(); load_use_x5();
        mid();
        chk("t2_pc_en", 32'(pc_en), 32'd0);
        chk("t2_id_ex_flush", 32'(id_ex_flush), 32'd1);
        nxt(); idle();
        mid();
        chk("t2_stall_count", 32'(stall_count), 32'd1);
        chk("t2_pc_en_after", 32'(pc_en), 32'd1);

        // Register 0 and unused sources never stall
        nxt(); load_use_x5(); ex_rd = 5'd0; id_rs1 = 5'd0;
        mid();
        chk("t2_x0_pc_en", 32'(pc_en), 32'd1);
        nxt(); load_use_x5(); id_use_rs1 = 1'b0;
        mid();
        chk("t2_unused_pc_en", 32'(pc_en), 32'd1);

        // Taken branch overrides load-use
        nxt(); load_use_x5(); ex_branch_taken = 1'b1;
        mid();
        chk("t3_pc_en", 32'(pc_en), 32'd1);
        chk("t3_if_id_flush", 32'(if_id_flush), 32'd1);
        chk("t3_id_ex_flush", 32'(id_ex_flush), 32'd1);
        nxt(); idle();
        mid();
        chk("t3_stall_count", 32'(stall_count), 32'd1);

        // Multi-cycle op; branch during the hold is ignored
        nxt(); ex_multicycle = 1'b1;
        mid();
        chk("t4_detect_busy", 32'(mc_busy), 32'd0);
        nxt(); ex_multicycle = 1'b0; ex_branch_taken = 1'b1;
        mid();
        chk("t4_busy1", 32'(mc_busy), 32'd1);
        chk("t4_busy1_if_id_flush", 32'(if_id_flush), 32'd0);
        chk("t4_busy1_ex_mem_flush", 32'(ex_mem_flush), 32'd1);
        nxt(); ex_branch_taken = 1'b0;
        mid();
        chk("t4_busy2", 32'(mc_busy), 32'd1);
        nxt();
        mid();
        chk("t4_busy3_pc_en", 32'(pc_en), 32'd0);
        nxt();
        mid();
        chk("t4_done_busy", 32'(mc_busy), 32'd0);
        chk("t4_done_ex_mem_en", 32'(ex_mem_en), 32'd1);
        chk("t4_done_pc_en", 32'(pc_en), 32'd1);
        nxt();
        mid();
        chk("t4_run_pc_en", 32'(pc_en), 32'd1);
        chk("t4_stall_count", 32'(stall_count), 32'd4);
        chk("t4_stall_count_sat", 32'(s_stall_count), 32'd3);

        // Forwarding selects
        nxt(); idle();
        mem_rd = 5'd7; mem_regwrite = 1'b1; wb_rd = 5'd7; wb_regwrite = 1'b1; ex_rs1 = 5'd7;
        mid();
`ifdef HAZARD_FWD_EN
        chk("t5_fwd_a_exmem", 32'(fwd_a_sel), 32'd1);
`else
        chk("t5_fwd_a_off", 32'(fwd_a_sel), 32'd0);
`endif
        nxt(); mem_regwrite = 1'b0;
        mid();
`ifdef HAZARD_FWD_EN
        chk("t5_fwd_a_memwb", 32'(fwd_a_sel), 32'd2);
`else
        chk("t5_fwd_a_off2", 32'(fwd_a_sel), 32'd0);
`endif
        nxt(); mem_rd = 5'd0; mem_regwrite = 1'b1; wb_rd = 5'd0; ex_rs2 = 5'd0;
        mid();
        chk("t5_fwd_b_x0", 32'(fwd_b_sel), 32'd0);

        // RAW on non-load EX producer, repeated; MEM producer; WB producer
        nxt(); idle(); ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
        mid();
`ifdef HAZARD_FWD_EN
        chk("t6_raw_ex_pc_en", 32'(pc_en), 32'd1);
`else
        chk("t6_raw_ex_pc_en", 32'(pc_en), 32'd0);
`endif
        nxt();
        mid();
`ifdef HAZARD_FWD_EN
        chk("t6_raw_ex_repeat", 32'(pc_en), 32'd1);
`else
        chk("t6_raw_ex_repeat", 32'(pc_en), 32'd0);
`endif
        nxt(); idle(); mem_rd = 5'd9; mem_regwrite = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        mid();
`ifdef HAZARD_FWD_EN
        chk("t6_raw_mem_pc_en", 32'(pc_en), 32'd1);
`else
        chk("t6_raw_mem_pc_en", 32'(pc_en), 32'd0);
`endif
        nxt(); idle(); wb_rd = 5'd9; wb_regwrite = 1'b1; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
        mid();
        chk("t6_raw_wb_pc_en", 32'(pc_en), 32'd1);

        // Reset in the middle of a multi-cycle hold
        nxt(); idle(); ex_multicycle = 1'b1;
        mid();
        nxt(); ex_multicycle = 1'b0;
        mid();
        chk("t6_mc_busy_pre", 32'(mc_busy), 32'd1);
        nxt(); rst = 1'b1;
        mid();
        chk("t6_rst_mc_busy", 32'(mc_busy), 32'd0);
        chk("t6_rst_pc_en", 32'(pc_en), 32'd0);
        nxt(); rst = 1'b0;
        mid();
        chk("t6_after_busy", 32'(mc_busy), 32'd0);
        chk("t6_after_pc_en", 32'(pc_en), 32'd1);
        chk("t6_after_stall_count", 32'(stall_count), 32'd0);
        nxt();
        mid();
        chk("t6_run_pc_en", 32'(pc_en), 32'd1);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
